// File: rtl/bus_arbiter.sv
// bus_arbiter: 68000 BR/BG/BGACK arbitration for NREQ DMA requesters.
// Requesters are picked round-robin. Each bus tenure is limited to HOLD_MAX
// cycles; a grant that runs that long is withdrawn and flagged with revoke.
//
// Ports
//   clk         system clock
//   por_n       synchronous active-low reset
//   as_n        bus address strobe from any master
//   bg_n        CPU bus grant
//   bgack_in_n  BGACK as seen on the wire (other masters)
//   dma_req_n   per-requester bus request, active-low level
//   br_n        bus request to the CPU
//   bgack_n     bus grant acknowledge driven by the arbiter
//   dma_gnt_n   per-requester grant, one-hot-low or all high
//   owner       index of the current owner, all ones when idle
//   revoke      one-cycle pulse when a tenure hits its limit
//
// state     | meaning
// S_IDLE    | no request seen, bus not requested
// S_REQ     | br_n asserted, waiting for bg_n
// S_WAIT_BUS| bg_n seen, waiting for as_n and bgack_in_n to go high
// S_OWN     | winner holds the bus, tenure counter running
// S_RELEASE | grant dropped, waiting for the owner's bus cycle to end
module bus_arbiter #(
  parameter int NREQ     = 2,
  parameter int HOLD_MAX = 64
) (
  input  logic                  clk,
  input  logic                  por_n,
  input  logic                  as_n,
  input  logic                  bg_n,
  input  logic                  bgack_in_n,
  input  logic [NREQ-1:0]       dma_req_n,
  output logic                  br_n,
  output logic                  bgack_n,
  output logic [NREQ-1:0]       dma_gnt_n,
  output logic [$clog2(NREQ):0] owner,
  output logic                  revoke
);
  localparam int OW = $clog2(NREQ) + 1;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam int SW = NREQ + 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_BUS,
    S_OWN,
    S_RELEASE
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   sync1_q, sync2_q;
  logic            br_n_q, br_n_d;
  logic            bgack_n_q, bgack_n_d;
  logic [NREQ-1:0] gnt_n_q, gnt_n_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic            revoke_q, revoke_d;
  logic [PW-1:0]   own_idx_q, own_idx_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            as_s, bg_s, bgack_in_s;
  logic [NREQ-1:0] req_s;
  logic            any_req;
  logic            owner_req_n;
  logic            win_found;
  logic [PW-1:0]   win_idx;

  assign {as_s, bg_s, bgack_in_s, req_s} = sync2_q;
  assign any_req = ~(&req_s);

  // Round-robin scan starting just after the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!win_found && (i == (int'(rr_q) + k) % NREQ) && !req_s[i]) begin
          win_found = 1'b1;
          win_idx   = PW'(i);
        end
      end
    end
  end

  always_comb begin
    owner_req_n = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == own_idx_q) owner_req_n = req_s[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    br_n_d    = br_n_q;
    bgack_n_d = bgack_n_q;
    gnt_n_d   = gnt_n_q;
    owner_d   = owner_q;
    own_idx_d = own_idx_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    revoke_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_REQ;
          br_n_d  = 1'b0;
        end
      end
      S_REQ: begin
        if (!any_req) begin
          state_d = S_IDLE;
          br_n_d  = 1'b1;
        end else if (!bg_s) begin
          state_d = S_WAIT_BUS;
        end
      end
      S_WAIT_BUS: begin
        if (!any_req) begin
          state_d = S_IDLE;
          br_n_d  = 1'b1;
        end else if (as_s && bgack_in_s && win_found) begin
          state_d   = S_OWN;
          bgack_n_d = 1'b0;
          br_n_d    = 1'b1;
          owner_d   = OW'(win_idx);
          own_idx_d = win_idx;
          rr_d      = win_idx;
          cnt_d     = '0;
          for (int i = 0; i < NREQ; i++) gnt_n_d[i] = (PW'(i) != win_idx);
        end
      end
      S_OWN: begin
        // A voluntary release takes priority over the tenure limit.
        if (owner_req_n) begin
          state_d = S_RELEASE;
          gnt_n_d = '1;
        end else if (cnt_q == CW'(HOLD_MAX - 1)) begin
          state_d  = S_RELEASE;
          gnt_n_d  = '1;
          revoke_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RELEASE: begin
        if (as_s) begin
          state_d   = S_IDLE;
          bgack_n_d = 1'b1;
          owner_d   = '1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!por_n) begin
      state_q   <= S_IDLE;
      sync1_q   <= '1;
      sync2_q   <= '1;
      br_n_q    <= 1'b1;
      bgack_n_q <= 1'b1;
      gnt_n_q   <= '1;
      owner_q   <= '1;
      revoke_q  <= 1'b0;
      own_idx_q <= '0;
      rr_q      <= PW'(NREQ - 1);
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= {as_n, bg_n, bgack_in_n, dma_req_n};
      sync2_q   <= sync1_q;
      br_n_q    <= br_n_d;
      bgack_n_q <= bgack_n_d;
      gnt_n_q   <= gnt_n_d;
      owner_q   <= owner_d;
      revoke_q  <= revoke_d;
      own_idx_q <= own_idx_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign br_n      = br_n_q;
  assign bgack_n   = bgack_n_q;
  assign dma_gnt_n = gnt_n_q;
  assign owner     = owner_q;
  assign revoke    = revoke_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter with NREQ=2, HOLD_MAX=8.
module tb_bus_arbiter;
  localparam int NREQ = 2;
  localparam int HOLD = 8;
  localparam int RN   = 3000;

  logic       clk;
  logic       por_n;
  logic       as_n;
  logic       bg_n;
  logic       bgack_in_n;
  logic [1:0] dma_req_n;
  logic       br_n;
  logic       bgack_n;
  logic [1:0] dma_gnt_n;
  logic [1:0] owner;
  logic       revoke;

  int   total = 0;
  int   bad = 0;
  logic auto_bg = 1'b0;

  typedef struct {
    logic       por, a, bg, bgi;
    logic [1:0] req;
    logic       br, bk;
    logic [1:0] gnt, own;
    logic       rev;
    int         rep;
  } vec_t;
  vec_t tbl[$];

  logic [1:0] h_req [RN+2];
  logic       h_as  [RN+2];
  logic       h_bgi [RN+2];
  int         phase, rr, w, j, grants, revokes, g;
  logic [1:0] sreq, eg, exp_g, exp_o;
  logic       exp_r, exp_b, stayed, never_gnt;
  int         cont_exp [3];

  bus_arbiter #(.NREQ(NREQ), .HOLD_MAX(HOLD)) dut (
    .clk(clk), .por_n(por_n), .as_n(as_n), .bg_n(bg_n), .bgack_in_n(bgack_in_n),
    .dma_req_n(dma_req_n), .br_n(br_n), .bgack_n(bgack_n), .dma_gnt_n(dma_gnt_n),
    .owner(owner), .revoke(revoke)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // One clock: outputs are looked at on the falling edge after each rising edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (auto_bg) bg_n = br_n;
  endtask

  function automatic logic [15:0] outs();
    return {9'b0, br_n, bgack_n, dma_gnt_n, owner, revoke};
  endfunction

  task automatic addv(input logic por, a, bg, bgi, input logic [1:0] req,
                      input logic br, bk, input logic [1:0] gnt, own,
                      input logic rev, input int rep);
    vec_t v;
    v.por = por; v.a = a; v.bg = bg; v.bgi = bgi; v.req = req;
    v.br = br; v.bk = bk; v.gnt = gnt; v.own = own; v.rev = rev; v.rep = rep;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    auto_bg = 1'b0;
    por_n = 1'b0; as_n = 1'b1; bg_n = 1'b1; bgack_in_n = 1'b1; dma_req_n = 2'b11;
    tick();
    tick();
    por_n = 1'b1;
  endtask

  task automatic wait_owner(input string nm, input logic want_idle);
    int n = 0;
    while (((owner == 2'b11) != want_idle) && n < 80) begin
      tick();
      n++;
    end
    chk(nm, 16'(n >= 80), 16'd0);
  endtask

  task automatic wait_bg(input string nm);
    int n = 0;
    while (bg_n !== 1'b0 && n < 80) begin
      tick();
      n++;
    end
    chk(nm, 16'(n >= 80), 16'd0);
  endtask

  initial begin
    por_n = 1'b0; as_n = 1'b1; bg_n = 1'b1; bgack_in_n = 1'b1; dma_req_n = 2'b11;

    // Single request on requester 0, tenure limit reached, then a withdrawn re-request.
    // Row n: inputs sampled at edge n, outputs checked after edge n.
    //     por a bg bgi req    br bk gnt    own    rev rep
    addv(0, 1, 1, 1, 2'b11, 1, 1, 2'b11, 2'b11, 0, 2);
    addv(1, 1, 1, 1, 2'b10, 1, 1, 2'b11, 2'b11, 0, 2);
    addv(1, 1, 1, 1, 2'b10, 0, 1, 2'b11, 2'b11, 0, 1);
    addv(1, 1, 0, 1, 2'b10, 0, 1, 2'b11, 2'b11, 0, 3);
    addv(1, 1, 0, 1, 2'b10, 1, 0, 2'b10, 2'b00, 0, 1);
    addv(1, 1, 1, 1, 2'b10, 1, 0, 2'b10, 2'b00, 0, 7);
    addv(1, 1, 1, 1, 2'b10, 1, 0, 2'b11, 2'b00, 1, 1);
    addv(1, 1, 1, 1, 2'b10, 1, 1, 2'b11, 2'b11, 0, 1);
    addv(1, 1, 1, 1, 2'b11, 0, 1, 2'b11, 2'b11, 0, 2);
    addv(1, 1, 1, 1, 2'b11, 1, 1, 2'b11, 2'b11, 0, 2);

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        por_n = tbl[i].por; as_n = tbl[i].a; bg_n = tbl[i].bg;
        bgack_in_n = tbl[i].bgi; dma_req_n = tbl[i].req;
        tick();
        chk($sformatf("vec%0d_%0d", i, r), outs(),
            {9'b0, tbl[i].br, tbl[i].bk, tbl[i].gnt, tbl[i].own, tbl[i].rev});
      end
    end

    // Contention: both requesting, each drops 5 cycles into its tenure.
    cont_exp = '{0, 1, 0};
    do_reset();
    auto_bg = 1'b1;
    dma_req_n = 2'b00;
    for (int t = 0; t < 3; t++) begin
      wait_owner($sformatf("cont_busy%0d", t), 1'b0);
      chk($sformatf("cont_owner%0d", t), 16'(owner), 16'(cont_exp[t]));
      chk($sformatf("cont_gnt%0d", t), 16'(dma_gnt_n), 16'(2'b11 & ~(2'(1) << cont_exp[t])));
      g = int'(owner);
      repeat (5) tick();
      dma_req_n = dma_req_n | (2'(1) << g);
      wait_owner($sformatf("cont_idle%0d", t), 1'b1);
      dma_req_n = dma_req_n & ~(2'(1) << g);
    end
    dma_req_n = 2'b11;
    wait_owner("cont_end", 1'b1);

    // Bus busy: as_n held low while bg_n is granted.
    do_reset();
    auto_bg = 1'b1;
    as_n = 1'b0;
    dma_req_n = 2'b10;
    wait_bg("busy_as_bg");
    stayed = 1'b1;
    repeat (10) begin
      tick();
      stayed = stayed & bgack_n;
    end
    chk("busy_as_hold", 16'(stayed), 16'd1);
    as_n = 1'b1;
    tick(); chk("busy_as_e0", 16'(bgack_n), 16'd1);
    tick(); chk("busy_as_e1", 16'(bgack_n), 16'd1);
    tick(); chk("busy_as_e2", 16'({bgack_n, dma_gnt_n}), 16'b010);
    dma_req_n = 2'b11;
    wait_owner("busy_as_idle", 1'b1);

    // Bus busy: another master's BGACK on the wire.
    bgack_in_n = 1'b0;
    dma_req_n = 2'b01;
    wait_bg("busy_bgi_bg");
    stayed = 1'b1;
    repeat (10) begin
      tick();
      stayed = stayed & bgack_n;
    end
    chk("busy_bgi_hold", 16'(stayed), 16'd1);
    bgack_in_n = 1'b1;
    tick(); chk("busy_bgi_e0", 16'(bgack_n), 16'd1);
    tick(); chk("busy_bgi_e1", 16'(bgack_n), 16'd1);
    tick(); chk("busy_bgi_e2", 16'({bgack_n, dma_gnt_n}), 16'b001);
    dma_req_n = 2'b11;
    wait_owner("busy_bgi_idle", 1'b1);

    // Withdrawn request before bg_n ever falls.
    do_reset();
    dma_req_n = 2'b01;
    never_gnt = 1'b1;
    tick(); tick(); tick();
    chk("wd_br_low", 16'(br_n), 16'd0);
    dma_req_n = 2'b11;
    tick(); tick();
    chk("wd_br_hold", 16'(br_n), 16'd0);
    tick();
    chk("wd_br_high", 16'(br_n), 16'd1);
    repeat (10) begin
      tick();
      never_gnt = never_gnt & (&dma_gnt_n) & bgack_n;
    end
    chk("wd_no_grant", 16'(never_gnt), 16'd1);

    // Reset in the middle of a tenure.
    do_reset();
    auto_bg = 1'b1;
    dma_req_n = 2'b10;
    wait_owner("rst_busy", 1'b0);
    chk("rst_owner_pre", 16'(owner), 16'd0);
    repeat (3) tick();
    por_n = 1'b0;
    tick();
    chk("rst_outs", outs(), {9'b0, 1'b1, 1'b1, 2'b11, 2'b11, 1'b0});
    por_n = 1'b1;
    dma_req_n = 2'b00;
    wait_owner("rst_regrant", 1'b0);
    chk("rst_owner_post", 16'(owner), 16'd0);

    // Randomized traffic against a tenure-level model. h_*[e] is what edge e sampled;
    // the controller acts on h_*[e-2].
    do_reset();
    h_req[0] = 2'b11; h_req[1] = 2'b11;
    h_as[0] = 1'b1; h_as[1] = 1'b1; h_bgi[0] = 1'b1; h_bgi[1] = 1'b1;
    phase = 0; rr = NREQ - 1; grants = 0; revokes = 0; w = 0; j = 0; eg = 2'b11;
    for (int e = 2; e < RN + 2; e++) begin
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(0, 9) == 0) dma_req_n = dma_req_n ^ (2'(1) << b);
      as_n = ($urandom_range(0, 3) != 0);
      bgack_in_n = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 4) != 0) bg_n = br_n;
      h_req[e] = dma_req_n; h_as[e] = as_n; h_bgi[e] = bgack_in_n;
      @(posedge clk);
      @(negedge clk);
      sreq = h_req[e-2];
      if (phase == 0) begin
        if (dma_gnt_n == 2'b11) begin
          chk("rnd_free", 16'({owner, revoke}), 16'b110);
        end else begin
          w = -1;
          for (int k = 1; k <= NREQ; k++)
            if (w < 0 && ((sreq >> ((rr + k) % NREQ)) & 2'b01) == 2'b00) w = (rr + k) % NREQ;
          if (w < 0) begin
            chk("rnd_spurious", 16'(dma_gnt_n), 16'b11);
          end else begin
            eg = 2'b11 & ~(2'(1) << w);
            chk("rnd_win", 16'({dma_gnt_n, owner, bgack_n, br_n, revoke}),
                16'({eg, 2'(w), 3'b010}));
            chk("rnd_bus_free", 16'({h_as[e-2], h_bgi[e-2]}), 16'b11);
            rr = w; j = 0; phase = 1; grants++;
          end
        end
      end else if (phase == 1) begin
        j++;
        if (((sreq >> w) & 2'b01) != 2'b00) begin
          exp_g = 2'b11; exp_r = 1'b0; phase = 2;
        end else if (j == HOLD) begin
          exp_g = 2'b11; exp_r = 1'b1; phase = 2; revokes++;
        end else begin
          exp_g = eg; exp_r = 1'b0;
        end
        chk("rnd_own", 16'({dma_gnt_n, owner, bgack_n, revoke}),
            16'({exp_g, 2'(w), 1'b0, exp_r}));
      end else begin
        if (h_as[e-2]) begin
          exp_o = 2'b11; exp_b = 1'b1; phase = 0;
        end else begin
          exp_o = 2'(w); exp_b = 1'b0;
        end
        chk("rnd_rel", 16'({dma_gnt_n, owner, bgack_n, revoke}),
            16'({2'b11, exp_o, exp_b, 1'b0}));
      end
    end
    chk("rnd_grants", 16'(grants >= 20), 16'd1);
    chk("rnd_revokes", 16'(revokes > 0), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
